// File: rtl/mem_access_stage_if.sv
// Execute-to-memory/writeback bus of the 8-bit MIPS pipeline.
// master: execute side (drives instruction, sees Stall/writeback); slave: mem_access_stage.
interface mem_access_stage_if;
   logic       Valid_ex;
   logic [7:0] ans_ex;
   logic [7:0] B_bypass;
   logic       Mem_en_ex;
   logic       Mem_rw_ex;
   logic       Mem_mux_sel_ex;
   logic [4:0] Rw_ex;
   logic       Stall;
   logic [7:0] Wb_data;
   logic [4:0] Rw_wb;
   logic       Wb_en;

   modport master (
      output Valid_ex, ans_ex, B_bypass, Mem_en_ex,
      output Mem_rw_ex, Mem_mux_sel_ex, Rw_ex,
      input  Stall, Wb_data, Rw_wb, Wb_en
   );

   modport slave (
      input  Valid_ex, ans_ex, B_bypass, Mem_en_ex,
      input  Mem_rw_ex, Mem_mux_sel_ex, Rw_ex,
      output Stall, Wb_data, Rw_wb, Wb_en
   );
endinterface

// File: rtl/mem_access_stage.sv
// Memory-access/writeback stage: data RAM, wait-stated loads/stores, stall, writeback.
// Ports: Clk4, Rst (sync, active-high), bus (mem_access_stage_if.slave).
// Optional DMEM_ZERO_INIT_EN: zero the RAM one word per cycle after reset (CLEAR state).
module mem_access_stage #(
   parameter int ADDR_W      = 8,
   parameter int WAIT_STATES = 1
) (
   input  logic                  Clk4,
   input  logic                  Rst,
   mem_access_stage_if.slave     bus
);

`ifdef DMEM_ZERO_INIT_EN
   typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_CLEAR} state_t;
   localparam state_t RST_STATE = S_CLEAR;
`else
   typedef enum logic [1:0] {S_IDLE, S_ACCESS} state_t;
   localparam state_t RST_STATE = S_IDLE;
`endif

   localparam int DEPTH = 1 << ADDR_W;

   logic [7:0]        r_mem [0:DEPTH-1];
   state_t            r_state;
   state_t            w_next;
   logic [1:0]        r_cnt;
   logic [ADDR_W-1:0] r_addr;
   logic [7:0]        r_sdata;
   logic [7:0]        r_ans;
   logic              r_store;
   logic              r_sel;
   logic [4:0]        r_dst;
   logic [7:0]        r_wb_data;
   logic [4:0]        r_rw_wb;
   logic              r_wb_en;
`ifdef DMEM_ZERO_INIT_EN
   logic [ADDR_W-1:0] r_clr_addr;
`endif

   logic              w_mem_we;
   logic [ADDR_W-1:0] w_mem_addr;
   logic [7:0]        w_mem_wdata;
   logic [7:0]        w_rdata;

   assign w_rdata     = r_mem[r_addr];
   assign bus.Stall   = (r_state != S_IDLE);
   assign bus.Wb_data = r_wb_data;
   assign bus.Rw_wb   = r_rw_wb;
   assign bus.Wb_en   = r_wb_en;

   always_comb begin
      w_next      = r_state;
      w_mem_we    = 1'b0;
      w_mem_addr  = r_addr;
      w_mem_wdata = r_sdata;
      unique case (r_state)
         S_IDLE: begin
            if (bus.Valid_ex && bus.Mem_en_ex)
               w_next = S_ACCESS;
         end
         S_ACCESS: begin
            if (r_cnt == 2'd0) begin
               w_next   = S_IDLE;
               w_mem_we = r_store;
            end
         end
`ifdef DMEM_ZERO_INIT_EN
         S_CLEAR: begin
            w_mem_we    = 1'b1;
            w_mem_addr  = r_clr_addr;
            w_mem_wdata = 8'h00;
            if (&r_clr_addr)
               w_next = S_IDLE;
         end
`endif
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge Clk4) begin
      if (Rst) r_state <= RST_STATE;
      else     r_state <= w_next;
   end

   // Reset gates the write so an abort in the final cycle leaves RAM intact.
   always_ff @(posedge Clk4) begin
      if (!Rst && w_mem_we)
         r_mem[w_mem_addr] <= w_mem_wdata;
   end

   always_ff @(posedge Clk4) begin
      if (Rst) begin
         r_cnt     <= 2'd0;
         r_addr    <= '0;
         r_sdata   <= 8'h00;
         r_ans     <= 8'h00;
         r_store   <= 1'b0;
         r_sel     <= 1'b0;
         r_dst     <= 5'd0;
         r_wb_data <= 8'h00;
         r_rw_wb   <= 5'd0;
         r_wb_en   <= 1'b0;
`ifdef DMEM_ZERO_INIT_EN
         r_clr_addr <= '0;
`endif
      end else begin
         r_wb_en <= 1'b0;
         unique case (r_state)
            S_IDLE: begin
               if (bus.Valid_ex) begin
                  if (bus.Mem_en_ex) begin
                     r_addr  <= bus.ans_ex[ADDR_W-1:0];
                     r_ans   <= bus.ans_ex;
                     r_sdata <= bus.B_bypass;
                     r_store <= bus.Mem_rw_ex;
                     r_sel   <= bus.Mem_mux_sel_ex;
                     r_dst   <= bus.Rw_ex;
                     r_cnt   <= 2'(WAIT_STATES);
                  end else begin
                     r_wb_data <= bus.ans_ex;
                     r_rw_wb   <= bus.Rw_ex;
                     r_wb_en   <= (bus.Rw_ex != 5'd0);
                  end
               end
            end
            S_ACCESS: begin
               if (r_cnt != 2'd0) begin
                  r_cnt <= r_cnt - 2'd1;
               end else if (!r_store) begin
                  r_wb_data <= r_sel ? w_rdata : r_ans;
                  r_rw_wb   <= r_dst;
                  r_wb_en   <= (r_dst != 5'd0);
               end
            end
`ifdef DMEM_ZERO_INIT_EN
            S_CLEAR: r_clr_addr <= r_clr_addr + 1'b1;
`endif
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access_stage.sv
// Randomized self-checking bench for mem_access_stage (ADDR_W=4, WAIT_STATES=1).
// Reference: per-instruction array model of RAM and writeback outputs.
module tb_mem_access_stage;
   localparam int AW    = 4;
   localparam int WS    = 1;
   localparam int DEPTH = 16;

   logic Clk4 = 1'b0;
   logic Rst  = 1'b1;
   int   n_chk = 0;
   int   n_err = 0;

   logic [7:0] m_mem [DEPTH];
   logic [7:0] m_data;
   logic [4:0] m_rw;
   logic       m_en;

   mem_access_stage_if bus ();

   mem_access_stage #(
      .ADDR_W      (AW),
      .WAIT_STATES (WS)
   ) dut (
      .Clk4 (Clk4),
      .Rst  (Rst),
      .bus  (bus)
   );

   always #5 Clk4 = ~Clk4;

   initial begin
      #2000000;
      $display("FAIL timeout");
      $fatal(1, "timeout");
   end

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic junk();
      bus.ans_ex         = 8'($urandom);
      bus.B_bypass       = 8'($urandom);
      bus.Mem_en_ex      = 1'($urandom);
      bus.Mem_rw_ex      = 1'($urandom);
      bus.Mem_mux_sel_ex = 1'($urandom);
      bus.Rw_ex          = 5'($urandom);
   endtask

   task automatic chk_out(string tag);
      chk({tag, "_stall"}, 32'(bus.Stall), 32'd0);
      chk({tag, "_en"}, 32'(bus.Wb_en), 32'(m_en));
      chk({tag, "_data"}, 32'(bus.Wb_data), 32'(m_data));
      chk({tag, "_rw"}, 32'(bus.Rw_wb), 32'(m_rw));
   endtask

   // Call with Rst already high, just before a rising edge.
   task automatic reset_seq();
      int n;
      @(posedge Clk4);
      #1 Rst = 1'b0;
      bus.Valid_ex = 1'b0;
      m_data = 8'h00;
      m_rw   = 5'd0;
      m_en   = 1'b0;
      @(negedge Clk4);
      chk("rst_en", 32'(bus.Wb_en), 32'd0);
      chk("rst_data", 32'(bus.Wb_data), 32'd0);
      chk("rst_rw", 32'(bus.Rw_wb), 32'd0);
`ifdef DMEM_ZERO_INIT_EN
      foreach (m_mem[i]) m_mem[i] = 8'h00;
      n = 0;
      while (bus.Stall && n < 100) begin
         n++;
         // Valid_ex must be ignored while clearing
         bus.Valid_ex = 1'b1;
         junk();
         @(posedge Clk4);
         @(negedge Clk4);
      end
      bus.Valid_ex = 1'b0;
      chk("clr_len", 32'(n), 32'(DEPTH));
`else
      n = 0;
      chk("rst_stall", 32'(bus.Stall), 32'(n));
`endif
   endtask

   task automatic issue(input logic v, input logic [7:0] ans,
                        input logic [7:0] b, input logic men,
                        input logic mrw, input logic sel,
                        input logic [4:0] rw);
      int a;
      a = int'(ans) % DEPTH;
      bus.Valid_ex       = v;
      bus.ans_ex         = ans;
      bus.B_bypass       = b;
      bus.Mem_en_ex      = men;
      bus.Mem_rw_ex      = mrw;
      bus.Mem_mux_sel_ex = sel;
      bus.Rw_ex          = rw;
      @(posedge Clk4);
      #1;
      if (v && men) begin
         bus.Valid_ex = 1'b1;
         junk();
         for (int i = 0; i <= WS; i++) begin
            @(negedge Clk4);
            chk("busy_stall", 32'(bus.Stall), 32'd1);
            chk("busy_en", 32'(bus.Wb_en), 32'd0);
            @(posedge Clk4);
            #1;
         end
         bus.Valid_ex = 1'b0;
         if (mrw) begin
            m_mem[a] = b;
            m_en = 1'b0;
         end else begin
            m_data = sel ? m_mem[a] : ans;
            m_rw   = rw;
            m_en   = (rw != 5'd0);
         end
      end else begin
         bus.Valid_ex = 1'b0;
         if (v) begin
            m_data = ans;
            m_rw   = rw;
            m_en   = (rw != 5'd0);
         end else begin
            m_en = 1'b0;
         end
      end
      @(negedge Clk4);
      chk_out(men && v ? (mrw ? "st" : "ld") : (v ? "alu" : "idle"));
   endtask

   // Store aborted by reset during its last ACCESS cycle.
   task automatic store_abort(input logic [7:0] ans, input logic [7:0] b);
      bus.Valid_ex  = 1'b1;
      bus.ans_ex    = ans;
      bus.B_bypass  = b;
      bus.Mem_en_ex = 1'b1;
      bus.Mem_rw_ex = 1'b1;
      bus.Rw_ex     = 5'd3;
      @(posedge Clk4);
      #1 bus.Valid_ex = 1'b0;
      for (int i = 0; i < WS; i++) begin
         @(negedge Clk4);
         chk("abort_stall", 32'(bus.Stall), 32'd1);
         @(posedge Clk4);
         #1;
      end
      Rst = 1'b1;
      reset_seq();
   endtask

   initial begin
      int kind;
      logic [4:0] rw;
      bus.Valid_ex = 1'b0;
      junk();
      foreach (m_mem[i]) m_mem[i] = 8'h00;
      reset_seq();
`ifdef DMEM_ZERO_INIT_EN
      issue(1, 8'h05, 8'h00, 1, 0, 1, 5'd3);
      issue(1, 8'hEB, 8'h00, 1, 0, 1, 5'd4);
`endif
      for (int i = 0; i < DEPTH; i++)
         issue(1, 8'(i), 8'($urandom), 1, 1, 0, 5'($urandom));
      issue(1, 8'h3C, 8'h00, 0, 0, 0, 5'd5);
      issue(1, 8'h41, 8'h00, 0, 0, 0, 5'd6);
      issue(0, 8'h00, 8'h00, 0, 0, 0, 5'd0);
      issue(1, 8'h10, 8'hA5, 1, 1, 0, 5'd2);
      issue(1, 8'h10, 8'h00, 1, 0, 1, 5'd7);
      issue(1, 8'h03, 8'h00, 1, 0, 1, 5'd0);
      issue(1, 8'h9E, 8'h00, 1, 0, 0, 5'd8);
      issue(1, 8'hFF, 8'h5A, 1, 1, 0, 5'd1);
      issue(1, 8'h0F, 8'h00, 1, 0, 1, 5'd9);
      store_abort(8'h10, 8'h77);
      issue(1, 8'h10, 8'h00, 1, 0, 1, 5'd7);
      for (int n = 0; n < 300; n++) begin
         kind = int'($urandom_range(0, 3));
         rw = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
         issue(kind != 0, 8'($urandom), 8'($urandom), kind >= 2,
               kind == 2, 1'($urandom), rw);
      end
      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end
endmodule
